processor_core: RTL and testbench
=================================

Name: processor_core

Overview:
- Minimal 16-bit multi-cycle processor: control unit plus datapath with eight 16-bit general registers R0..R7.
- Instructions are applied one 16-bit word per clock on `instr`. The bench holds each multi-cycle instruction word for its full cycle count.
- Supports LOAD (two words), MOV, ADD, XOR and NOP.
- A debug read port exposes any register for verification.

Parameters:
- NUM_REGS, 8, number of general registers (index field is 3 bits; fixed at 8)
- WIDTH, 16, register/datapath width in bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- instr  input  16  instruction word for the current cycle
- busy  output  1  high while a multi-cycle instruction is in step T1 or T2
- dbg_sel  input  3  register index for debug read
- dbg_data  output  16  combinational read of R[dbg_sel]

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-high (rst).
- Format:
  - opcode = instr[15:12]
  - RX = instr[10:8] (destination); instr[11] ignored
  - RY = instr[6:4] (source); instr[7] ignored
  - imm8 = instr[7:0]
- All state updates occur on the rising clk edge.
- Step counter states: T0 (decode), T1, T2.
- In T0, instr is latched into an internal IR. Later steps of the same instruction use IR. Exception: LOAD T1 reads imm8 from the live instr.
- Opcode 0000 LOAD (2 cycles):
  - T0: RX <= {8'h00, imm8}; go to T1.
  - T1: RX[15:8] <= instr[7:0] of the current word; RX[7:0] unchanged; go to T0.
- Opcode 0001 MOV (1 cycle): T0: RX <= RY; stay in T0. MOV RX,RX leaves RX unchanged.
- Opcode 0101 ADD (3 cycles):
  - T0: A <= RX.
  - T1: G <= A + RY, modulo 2^16, carry discarded.
  - T2: RX <= G; return to T0.
- Opcode 0111 XOR (3 cycles): same sequence as ADD with G <= A ^ RY.
- Opcode 1111 NOP, and all other opcodes: no state change; 1 cycle; stay in T0.
- RX == RY is legal for ADD/XOR:
  - ADD R5,R5 doubles R5.
  - XOR Rn,Rn clears Rn.
- busy = (step != T0). It is a registered state decode, valid the cycle after T0.
- Internal registers A and G are 16 bits. They are not architecturally visible.
- Reset:
  - R0..R7, A, G and IR cleared to 0.
  - Step counter to T0; busy = 0.
  - rst has priority over any instruction step.
  - Reset mid-instruction aborts it with no partial writeback; the next instruction decodes from T0.
- dbg_data is purely combinational from the register file. It reflects a write in the cycle after the clock edge that performs it.

Test Plan:
- Reset: assert rst 1 cycle, then NOP -> R0..R7 = 0, busy = 0, dbg_data = 0 for every dbg_sel.
- LOAD: 0x0103 then 0x0100 -> R1 = 0x0003. LOAD 0x0234 then 0x0212 -> R2 = 0x1234.
- MOV and ADD, with R1 = 3 from the LOAD test:
  - MOV 0x1510 -> R5 = 3 after 1 cycle.
  - ADD 0x5510 held 3 cycles -> busy = 1 during T1/T2; R5 = 6 after the third edge; R1 still 3.
- ADD wrap: R1 = 0xFFFF, R2 = 0x0002; ADD 0x5120 x3 -> R1 = 0x0001.
- XOR:
  - R3 = 0x00FF, R4 = 0x0F0F; XOR 0x7340 x3 -> R3 = 0x0FF0.
  - XOR 0x7000 x3 with R0 = 0 -> R0 = 0.
- Reset mid-op: start ADD R5,R1; assert rst in T1 -> all registers 0, step T0; next MOV executes normally.

Source files
------------

// File: rtl/processor_core.sv
// Minimal 16-bit multi-cycle processor: step-sequenced control unit plus a
// datapath of eight general registers, an accumulator A and a result latch G.
module processor_core #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    output logic             busy,
    input  logic [2:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2
    } step_e;

    typedef enum logic [3:0] {
        OP_LOAD = 4'b0000,
        OP_MOV  = 4'b0001,
        OP_ADD  = 4'b0101,
        OP_XOR  = 4'b0111
    } opcode_e;

    // Only the fields later steps need are kept from the latched word.
    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
    } ir_t;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] g_q, g_d;
    ir_t              ir_q, ir_d;
    step_e            step_q, step_d;
    logic             busy_q, busy_d;

    logic [3:0] op_live;
    logic [2:0] rx_live;
    logic [2:0] ry_live;

    assign op_live = instr[15:12];
    assign rx_live = instr[10:8];
    assign ry_live = instr[6:4];

    // NOTE: next-state logic uses blocking '=' with every output defaulted
    // first, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        regs_d = regs_q;
        a_d    = a_q;
        g_d    = g_q;
        ir_d   = ir_q;
        step_d = step_q;

        unique case (step_q)
            T0: begin
                ir_d = '{op: op_live, rx: rx_live, ry: ry_live};
                case (op_live)
                    OP_LOAD: begin
                        regs_d[rx_live] = {{(WIDTH-8){1'b0}}, instr[7:0]};
                        step_d          = T1;
                    end
                    OP_MOV: regs_d[rx_live] = regs_q[ry_live];
                    OP_ADD, OP_XOR: begin
                        a_d    = regs_q[rx_live];
                        step_d = T1;
                    end
                    default: ;
                endcase
            end
            T1: begin
                // LOAD's high byte comes from the live word, not from IR.
                case (ir_q.op)
                    OP_LOAD: begin
                        regs_d[ir_q.rx][15:8] = instr[7:0];
                        step_d                = T0;
                    end
                    OP_ADD: begin
                        g_d    = a_q + regs_q[ir_q.ry];
                        step_d = T2;
                    end
                    OP_XOR: begin
                        g_d    = a_q ^ regs_q[ir_q.ry];
                        step_d = T2;
                    end
                    default: step_d = T0;
                endcase
            end
            T2: begin
                regs_d[ir_q.rx] = g_q;
                step_d          = T0;
            end
            default: step_d = T0;
        endcase

        busy_d = (step_d != T0);
    end

    // NOTE: the register file is reset here because cleared registers are
    // architecturally visible after reset, unlike a plain storage RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            a_q    <= '0;
            g_q    <= '0;
            ir_q   <= '0;
            step_q <= T0;
            busy_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            a_q    <= a_d;
            g_q    <= g_d;
            ir_q   <= ir_d;
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_processor_core.sv
// Self-checking bench for processor_core: directed programs plus a random
// instruction stream, compared against an architectural register-file model.
module tb_processor_core;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        busy;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural view: just the eight registers.
    logic [15:0] model [8];

    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0111;

    processor_core dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .busy     (busy),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step(input logic [15:0] w);
        instr = w;
        @(posedge clk);
        #1;
    endtask

    task automatic compare_regs(input string nm);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            n_checks++;
            if (dbg_data !== model[i]) begin
                n_fail++;
                $display("FAIL %s R%0d: got %h expected %h", nm, i, dbg_data, model[i]);
            end
        end
    endtask

    task automatic do_load(input logic [2:0] rx, input logic [7:0] lo, input logic [7:0] hi);
        logic b11;
        b11 = 1'($urandom);
        step({4'h0, b11, rx, lo});
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_t0_busy: got %b expected 1", busy);
        end
        step({4'h0, b11, rx, hi});
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_t1_busy: got %b expected 0", busy);
        end
        model[rx] = {hi, lo};
    endtask

    task automatic do_mov(input logic [2:0] rx, input logic [2:0] ry);
        step({4'h1, 1'($urandom), rx, 1'($urandom), ry, 4'($urandom)});
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mov_busy: got %b expected 0", busy);
        end
        model[rx] = model[ry];
    endtask

    task automatic do_alu(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
        logic [15:0] w;
        logic [15:0] res;
        w   = {op, 1'($urandom), rx, 1'($urandom), ry, 4'($urandom)};
        res = (op == OP_ADD) ? model[rx] + model[ry] : model[rx] ^ model[ry];
        for (int s = 0; s < 3; s++) begin
            step(w);
            n_checks++;
            if (busy !== (s < 2)) begin
                n_fail++;
                $display("FAIL alu_busy_step%0d: got %b expected %b", s, busy, s < 2);
            end
            // The destination must not change before the final step.
            if (s < 2) begin
                dbg_sel = rx;
                #1;
                n_checks++;
                if (dbg_data !== model[rx]) begin
                    n_fail++;
                    $display("FAIL alu_early_write_step%0d: got %h expected %h",
                             s, dbg_data, model[rx]);
                end
            end
        end
        model[rx] = res;
    endtask

    task automatic do_nop();
        logic [3:0] op;
        op = 4'($urandom);
        if (op inside {4'h0, 4'h1, 4'h5, 4'h7}) op = 4'hF;
        step({op, 12'($urandom)});
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(16'($urandom));
        step(16'($urandom));
        rst = 1'b0;
        step(16'hF000);
        for (int i = 0; i < 8; i++) model[i] = '0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        compare_regs("reset");
    endtask

    task automatic test_load();
        do_load(3'd1, 8'h03, 8'h00);
        do_load(3'd2, 8'h34, 8'h12);
        n_checks++;
        if (model[2] !== 16'h1234 || model[1] !== 16'h0003) begin
            n_fail++;
            $display("FAIL load_model: got %h/%h expected 0003/1234", model[1], model[2]);
        end
        compare_regs("load");
    endtask

    task automatic test_mov_add();
        do_mov(3'd5, 3'd1);
        compare_regs("mov");
        do_alu(OP_ADD, 3'd5, 3'd1);
        compare_regs("add");
        do_mov(3'd4, 3'd4);
        compare_regs("mov_self");
    endtask

    task automatic test_add_wrap();
        do_load(3'd1, 8'hFF, 8'hFF);
        do_load(3'd2, 8'h02, 8'h00);
        do_alu(OP_ADD, 3'd1, 3'd2);
        compare_regs("add_wrap");
        do_alu(OP_ADD, 3'd2, 3'd2);
        compare_regs("add_double");
    endtask

    task automatic test_xor();
        do_load(3'd3, 8'hFF, 8'h00);
        do_load(3'd4, 8'h0F, 8'h0F);
        do_alu(OP_XOR, 3'd3, 3'd4);
        compare_regs("xor");
        do_alu(OP_XOR, 3'd0, 3'd0);
        compare_regs("xor_r0");
        do_alu(OP_XOR, 3'd4, 3'd4);
        compare_regs("xor_self_clear");
    endtask

    task automatic test_reset_mid_op();
        do_load(3'd1, 8'h03, 8'h00);
        do_load(3'd5, 8'h40, 8'h00);
        step({OP_ADD, 4'h5, 4'h1, 4'h0});
        rst = 1'b1;
        step({OP_ADD, 4'h5, 4'h1, 4'h0});
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %b expected 0", busy);
        end
        compare_regs("reset_mid");
        do_mov(3'd2, 3'd3);
        compare_regs("post_reset_mov");
        do_load(3'd6, 8'hCD, 8'hAB);
        do_mov(3'd7, 3'd6);
        compare_regs("post_reset_load_mov");
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 4))
                0: do_load(3'($urandom), 8'($urandom), 8'($urandom));
                1: do_mov(3'($urandom), 3'($urandom));
                2: do_alu(OP_ADD, 3'($urandom), 3'($urandom));
                3: do_alu(OP_XOR, 3'($urandom), 3'($urandom));
                default: do_nop();
            endcase
            compare_regs("random");
        end
    endtask

    initial begin
        rst     = 1'b1;
        instr   = 16'h0000;
        dbg_sel = 3'd0;
        test_reset();
        test_load();
        test_mov_add();
        test_add_wrap();
        test_xor();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
